ramb16_s1_arbiter: RTL and testbench

- Controller that shares one 16K x 1 single-port block RAM (sync write, registered read, 1-cycle read latency) between two requesters, A and B.
- Also contains a bulk-clear engine that writes a fixed value to every address.
- Sits between two client blocks and the RAM primitive; drives the RAM EN/WE/ADDR/DI pins and returns RAM DO to the winning reader.

---
 rtl/ramb16_s1_arbiter.sv | 149 ++++++++++++++
 tb/tb_ramb16_s1_arbiter.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramb16_s1_arbiter.sv
// ramb16_s1_arbiter: shares one 16K x 1 single-port block RAM
// between requesters A and B, plus a bulk-clear engine.
//
// Ports:
//   CLK, RST          clock, async active-high reset
//   REQ_x/WE_x/ADDR_x/DI_x  requester x (A or B); held until ACK_x
//   ACK_x             comb; request accepted this cycle
//   RVALID_x/RDATA_x  read data, valid one cycle after a read ACK
//   CLR_START/CLR_VAL start a sweep writing CLR_VAL everywhere
//   CLR_BUSY/CLR_DONE sweep in progress / one-cycle completion pulse
//   RAM_EN/WE/ADDR/DI/DO  block RAM pins
module ramb16_s1_arbiter #(
  parameter int ADDR_W    = 14,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_A,
  input  logic              WE_A,
  input  logic [ADDR_W-1:0] ADDR_A,
  input  logic              DI_A,
  output logic              ACK_A,
  output logic              RVALID_A,
  output logic              RDATA_A,
  input  logic              REQ_B,
  input  logic              WE_B,
  input  logic [ADDR_W-1:0] ADDR_B,
  input  logic              DI_B,
  output logic              ACK_B,
  output logic              RVALID_B,
  output logic              RDATA_B,
  input  logic              CLR_START,
  input  logic              CLR_VAL,
  output logic              CLR_BUSY,
  output logic              CLR_DONE,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_DI,
  input  logic              RAM_DO
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              last_b;
  logic              clr_val_q;

  logic idle;
  logic clearing;
  logic arb;
  logic a_wins;
  logic gnt_a;
  logic gnt_b;

  // Combinational outputs are forced low while RST is held,
  // so the reset gate is folded into the state qualifiers.
  always_comb begin
    idle     = (state == IDLE) && !RST;
    clearing = (state == CLEAR) && !RST;
    arb      = idle && !CLR_START;
    // A takes a tie when fixed priority is set or B won last.
    a_wins   = !REQ_B || FIXED_PRI || last_b;
    gnt_a    = arb && REQ_A && a_wins;
    gnt_b    = arb && REQ_B && !gnt_a;
  end

  assign ACK_A   = gnt_a;
  assign ACK_B   = gnt_b;
  assign RDATA_A = RAM_DO;
  assign RDATA_B = RAM_DO;

  always_comb begin
    RAM_EN   = 1'b0;
    RAM_WE   = 1'b0;
    RAM_ADDR = '0;
    RAM_DI   = 1'b0;
    unique case (1'b1)
      clearing: begin
        RAM_EN   = 1'b1;
        RAM_WE   = 1'b1;
        RAM_ADDR = cnt;
        RAM_DI   = clr_val_q;
      end
      gnt_a: begin
        RAM_EN   = 1'b1;
        RAM_WE   = WE_A;
        RAM_ADDR = ADDR_A;
        RAM_DI   = DI_A;
      end
      gnt_b: begin
        RAM_EN   = 1'b1;
        RAM_WE   = WE_B;
        RAM_ADDR = ADDR_B;
        RAM_DI   = DI_B;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      last_b    <= 1'b1;
      clr_val_q <= 1'b0;
      CLR_BUSY  <= 1'b0;
      CLR_DONE  <= 1'b0;
      RVALID_A  <= 1'b0;
      RVALID_B  <= 1'b0;
    end else begin
      RVALID_A <= gnt_a && !WE_A;
      RVALID_B <= gnt_b && !WE_B;
      CLR_DONE <= 1'b0;
      if (gnt_a) begin
        last_b <= 1'b0;
      end else if (gnt_b) begin
        last_b <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (CLR_START) begin
            state     <= CLEAR;
            cnt       <= '0;
            clr_val_q <= CLR_VAL;
            CLR_BUSY  <= 1'b1;
          end
        end
        CLEAR: begin
          // Counter wraps to zero on the final write.
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= IDLE;
            CLR_BUSY <= 1'b0;
            CLR_DONE <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ramb16_s1_arbiter.sv
// tb_ramb16_s1_arbiter: bench for the RAM arbiter and clear engine.
// Drives a behavioural 16K x 1 RAM and checks against a memory model.
module tb_ramb16_s1_arbiter;

  localparam int N = 16384;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        REQ_A, WE_A, DI_A;
  logic        REQ_B, WE_B, DI_B;
  logic [13:0] ADDR_A, ADDR_B;
  logic        CLR_START, CLR_VAL;
  logic        ACK_A, RVALID_A, RDATA_A;
  logic        ACK_B, RVALID_B, RDATA_B;
  logic        CLR_BUSY, CLR_DONE;
  logic        RAM_EN, RAM_WE, RAM_DI, RAM_DO;
  logic [13:0] RAM_ADDR;

  logic        f_ack_a, f_rv_a, f_rd_a;
  logic        f_ack_b, f_rv_b, f_rd_b;
  logic        f_busy, f_done;
  logic        f_en, f_we, f_di;
  logic [13:0] f_addr;

  logic mem [0:N-1];
  logic ref_mem [0:N-1];

  int checks = 0;
  int fails  = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RAM_EN) begin
      if (RAM_WE) begin
        mem[RAM_ADDR] <= RAM_DI;
        RAM_DO        <= RAM_DI;
      end else begin
        RAM_DO <= mem[RAM_ADDR];
      end
    end
  end

  ramb16_s1_arbiter #(.ADDR_W(14), .FIXED_PRI(1'b0)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_A(REQ_A), .WE_A(WE_A), .ADDR_A(ADDR_A), .DI_A(DI_A),
    .ACK_A(ACK_A), .RVALID_A(RVALID_A), .RDATA_A(RDATA_A),
    .REQ_B(REQ_B), .WE_B(WE_B), .ADDR_B(ADDR_B), .DI_B(DI_B),
    .ACK_B(ACK_B), .RVALID_B(RVALID_B), .RDATA_B(RDATA_B),
    .CLR_START(CLR_START), .CLR_VAL(CLR_VAL),
    .CLR_BUSY(CLR_BUSY), .CLR_DONE(CLR_DONE),
    .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR),
    .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
  );

  ramb16_s1_arbiter #(.ADDR_W(14), .FIXED_PRI(1'b1)) dut_fp (
    .CLK(CLK), .RST(RST),
    .REQ_A(REQ_A), .WE_A(WE_A), .ADDR_A(ADDR_A), .DI_A(DI_A),
    .ACK_A(f_ack_a), .RVALID_A(f_rv_a), .RDATA_A(f_rd_a),
    .REQ_B(REQ_B), .WE_B(WE_B), .ADDR_B(ADDR_B), .DI_B(DI_B),
    .ACK_B(f_ack_b), .RVALID_B(f_rv_b), .RDATA_B(f_rd_b),
    .CLR_START(CLR_START), .CLR_VAL(CLR_VAL),
    .CLR_BUSY(f_busy), .CLR_DONE(f_done),
    .RAM_EN(f_en), .RAM_WE(f_we), .RAM_ADDR(f_addr),
    .RAM_DI(f_di), .RAM_DO(1'b0)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    REQ_A = 0; WE_A = 0; ADDR_A = '0; DI_A = 0;
    REQ_B = 0; WE_B = 0; ADDR_B = '0; DI_B = 0;
    CLR_START = 0; CLR_VAL = 0;
  endtask

  task automatic wr_a(input logic [13:0] a, input logic d,
                      output logic ack);
    REQ_A = 1; WE_A = 1; ADDR_A = a; DI_A = d;
    @(negedge CLK);
    ack = ACK_A;
    tick();
    REQ_A = 0; WE_A = 0;
  endtask

  task automatic rd_a(input logic [13:0] a, output logic ack,
                      output logic v, output logic d);
    REQ_A = 1; WE_A = 0; ADDR_A = a;
    @(negedge CLK);
    ack = ACK_A;
    tick();
    REQ_A = 0;
    @(negedge CLK);
    v = RVALID_A;
    d = RDATA_A;
    tick();
  endtask

  task automatic clear_run(input logic v, input int restart_at,
                           output logic start_ok,
                           output int busy_n, output int done_n,
                           output int bad_n);
    busy_n = 0; done_n = 0; bad_n = 0;
    CLR_START = 1; CLR_VAL = v;
    @(negedge CLK);
    start_ok = !ACK_A && !ACK_B && !RAM_EN;
    tick();
    CLR_START = 0; CLR_VAL = ~v;
    for (int k = 0; k < 20000; k++) begin
      @(negedge CLK);
      if (CLR_DONE) done_n++;
      if (!CLR_BUSY) break;
      if (ACK_A || ACK_B || !RAM_EN || !RAM_WE ||
          RAM_DI !== v || RAM_ADDR !== k[13:0]) bad_n++;
      busy_n++;
      tick();
      CLR_START = (k + 1 == restart_at);
    end
  endtask

  task automatic test_reset();
    idle_in();
    REQ_A = 1; WE_A = 1; ADDR_A = 14'h5; DI_A = 1;
    #2 RST = 1;
    #1;
    checks++;
    if (ACK_A !== 0 || RAM_EN !== 0 || RAM_WE !== 0 ||
        RAM_ADDR !== 0 || RAM_DI !== 0) begin
      fails++;
      $display("FAIL reset_comb ack=%b en=%b we=%b addr=%h di=%b want 0",
               ACK_A, RAM_EN, RAM_WE, RAM_ADDR, RAM_DI);
    end
    tick();
    tick();
    @(negedge CLK);
    checks++;
    if ({CLR_BUSY, CLR_DONE, RVALID_A, RVALID_B} !== 4'b0) begin
      fails++;
      $display("FAIL reset_regs busy/done/rva/rvb=%b want 0000",
               {CLR_BUSY, CLR_DONE, RVALID_A, RVALID_B});
    end
    tick();
    idle_in();
    RST = 0;
  endtask

  task automatic test_write_read();
    logic ack, v, d;
    REQ_A = 1; WE_A = 1; ADDR_A = 14'h5; DI_A = 1;
    @(negedge CLK);
    checks++;
    if (ACK_A !== 1 || RAM_EN !== 1 || RAM_WE !== 1 ||
        RAM_ADDR !== 14'h5 || RAM_DI !== 1) begin
      fails++;
      $display("FAIL wr_pins ack=%b en=%b we=%b addr=%h di=%b want 1 1 1 0005 1",
               ACK_A, RAM_EN, RAM_WE, RAM_ADDR, RAM_DI);
    end
    tick();
    ref_mem[5] = 1;
    WE_A = 0;
    @(negedge CLK);
    checks++;
    if (ACK_A !== 1 || RVALID_A !== 0) begin
      fails++;
      $display("FAIL rd_ack ack=%b rvalid=%b want 1 0", ACK_A, RVALID_A);
    end
    tick();
    REQ_A = 0;
    @(negedge CLK);
    checks++;
    if (RVALID_A !== 1 || RDATA_A !== 1 || RVALID_B !== 0) begin
      fails++;
      $display("FAIL rd_data rva=%b rd=%b rvb=%b want 1 1 0",
               RVALID_A, RDATA_A, RVALID_B);
    end
    tick();
    REQ_B = 1; WE_B = 1; ADDR_B = 14'h6; DI_B = 0;
    @(negedge CLK);
    checks++;
    if (ACK_B !== 1 || ACK_A !== 0 || RAM_ADDR !== 14'h6) begin
      fails++;
      $display("FAIL wr_b ackb=%b acka=%b addr=%h want 1 0 0006",
               ACK_B, ACK_A, RAM_ADDR);
    end
    tick();
    ref_mem[6] = 0;
    idle_in();
    rd_a(14'h6, ack, v, d);
    checks++;
    if (ack !== 1 || v !== 1 || d !== 0) begin
      fails++;
      $display("FAIL rd_6 ack=%b v=%b d=%b want 1 1 0", ack, v, d);
    end
    REQ_B = 1; WE_B = 1; ADDR_B = 14'h6; DI_B = 0;
    tick();
    idle_in();
  endtask

  task automatic test_round_robin();
    logic exp_a;
    REQ_A = 1; WE_A = 0; ADDR_A = 14'h5;
    REQ_B = 1; WE_B = 0; ADDR_B = 14'h6;
    for (int i = 0; i < 6; i++) begin
      exp_a = (i % 2 == 0);
      @(negedge CLK);
      checks++;
      if (ACK_A !== exp_a || ACK_B !== !exp_a ||
          RAM_ADDR !== (exp_a ? 14'h5 : 14'h6)) begin
        fails++;
        $display("FAIL rr_ack[%0d] a=%b b=%b addr=%h want a=%b",
                 i, ACK_A, ACK_B, RAM_ADDR, exp_a);
      end
      checks++;
      if (f_ack_a !== 1 || f_ack_b !== 0) begin
        fails++;
        $display("FAIL fp_ack[%0d] a=%b b=%b want 1 0",
                 i, f_ack_a, f_ack_b);
      end
      if (i > 0) begin
        checks++;
        if (RVALID_A !== !exp_a || RVALID_B !== exp_a ||
            RAM_DO !== !exp_a) begin
          fails++;
          $display("FAIL rr_rv[%0d] rva=%b rvb=%b do=%b want %b %b %b",
                   i, RVALID_A, RVALID_B, RAM_DO, !exp_a, exp_a, !exp_a);
        end
      end
      tick();
    end
    REQ_A = 0;
    @(negedge CLK);
    checks++;
    if (f_ack_b !== 1 || ACK_B !== 1 || RVALID_B !== 1 ||
        RDATA_B !== 0) begin
      fails++;
      $display("FAIL fp_drop fpb=%b ackb=%b rvb=%b rd=%b want 1 1 1 0",
               f_ack_b, ACK_B, RVALID_B, RDATA_B);
    end
    tick();
    idle_in();
    @(negedge CLK);
    checks++;
    if (RVALID_B !== 1 || RVALID_A !== 0 || RDATA_B !== 0) begin
      fails++;
      $display("FAIL rr_tail rvb=%b rva=%b rd=%b want 1 0 0",
               RVALID_B, RVALID_A, RDATA_B);
    end
    tick();
  endtask

  task automatic test_clear();
    logic ack, v, d, sok;
    int busy_n, done_n, bad_n;
    logic [13:0] adr [3];
    adr[0] = 14'h0; adr[1] = 14'h1FFF; adr[2] = 14'h3FFF;
    for (int i = 0; i < 3; i++) begin
      wr_a(adr[i], 1'b1, ack);
      ref_mem[adr[i]] = 1;
      checks++;
      if (ack !== 1) begin
        fails++;
        $display("FAIL clr_prewr[%0d] ack=%b want 1", i, ack);
      end
    end
    REQ_B = 1; WE_B = 0; ADDR_B = 14'h1FFF;
    clear_run(1'b0, -1, sok, busy_n, done_n, bad_n);
    for (int i = 0; i < N; i++) ref_mem[i] = 0;
    checks++;
    if (sok !== 1 || bad_n != 0) begin
      fails++;
      $display("FAIL clr_cycles start_ok=%b bad=%0d want 1 0", sok, bad_n);
    end
    checks++;
    if (busy_n != N || done_n != 1 || CLR_DONE !== 1) begin
      fails++;
      $display("FAIL clr_len busy=%0d done=%0d want %0d 1", busy_n, done_n, N);
    end
    checks++;
    if (ACK_B !== 1 || RAM_ADDR !== 14'h1FFF) begin
      fails++;
      $display("FAIL clr_pend ackb=%b addr=%h want 1 1fff", ACK_B, RAM_ADDR);
    end
    tick();
    REQ_B = 0;
    @(negedge CLK);
    checks++;
    if (RVALID_B !== 1 || RDATA_B !== ref_mem[14'h1FFF] ||
        CLR_DONE !== 0) begin
      fails++;
      $display("FAIL clr_rd_b rvb=%b rd=%b done=%b want 1 0 0",
               RVALID_B, RDATA_B, CLR_DONE);
    end
    tick();
    for (int i = 0; i < 3; i += 2) begin
      rd_a(adr[i], ack, v, d);
      checks++;
      if (ack !== 1 || v !== 1 || d !== ref_mem[adr[i]]) begin
        fails++;
        $display("FAIL clr_rd[%0d] ack=%b v=%b d=%b want 1 1 0",
                 i, ack, v, d);
      end
    end
  endtask

  task automatic test_clear_reset();
    logic ack, v, d;
    logic [13:0] adr [4];
    adr[0] = 14'd50; adr[1] = 14'd99; adr[2] = 14'd100; adr[3] = 14'd200;
    CLR_START = 1; CLR_VAL = 1;
    tick();
    CLR_START = 0;
    repeat (100) tick();
    #2 RST = 1;
    #1;
    checks++;
    if (CLR_BUSY !== 0 || RAM_EN !== 0 || RAM_WE !== 0 ||
        RAM_ADDR !== 0 || RAM_DI !== 0 || CLR_DONE !== 0) begin
      fails++;
      $display("FAIL rst_abort busy=%b en=%b we=%b addr=%h di=%b done=%b want 0",
               CLR_BUSY, RAM_EN, RAM_WE, RAM_ADDR, RAM_DI, CLR_DONE);
    end
    for (int i = 0; i < 100; i++) ref_mem[i] = 1;
    tick();
    RST = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++;
      if (CLR_DONE !== 0 || CLR_BUSY !== 0) begin
        fails++;
        $display("FAIL rst_nodone[%0d] done=%b busy=%b want 0 0",
                 i, CLR_DONE, CLR_BUSY);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      rd_a(adr[i], ack, v, d);
      checks++;
      if (ack !== 1 || v !== 1 || d !== ref_mem[adr[i]]) begin
        fails++;
        $display("FAIL rst_rd addr=%0d ack=%b v=%b d=%b want 1 1 %b",
                 adr[i], ack, v, d, ref_mem[adr[i]]);
      end
    end
  endtask

  task automatic test_clear_restart();
    logic ack, v, d, sok;
    int busy_n, done_n, bad_n;
    clear_run(1'b1, 5000, sok, busy_n, done_n, bad_n);
    for (int i = 0; i < N; i++) ref_mem[i] = 1;
    checks++;
    if (sok !== 1 || bad_n != 0 || busy_n != N || done_n != 1) begin
      fails++;
      $display("FAIL restart ok=%b bad=%0d busy=%0d done=%0d want 1 0 %0d 1",
               sok, bad_n, busy_n, done_n, N);
    end
    tick();
    @(negedge CLK);
    checks++;
    if (CLR_DONE !== 0 || CLR_BUSY !== 0) begin
      fails++;
      $display("FAIL restart_tail done=%b busy=%b want 0 0",
               CLR_DONE, CLR_BUSY);
    end
    tick();
    rd_a(14'h3FFF, ack, v, d);
    checks++;
    if (ack !== 1 || v !== 1 || d !== 1) begin
      fails++;
      $display("FAIL restart_rd ack=%b v=%b d=%b want 1 1 1", ack, v, d);
    end
  endtask

  task automatic test_random();
    logic pa, pb, last_was_b, ga, gb;
    logic ev_a, ev_b, ed_a, ed_b;
    logic [13:0] wa;
    RST = 1;
    tick();
    RST = 0;
    idle_in();
    pa = 0; pb = 0; last_was_b = 1;
    ev_a = 0; ev_b = 0; ed_a = 0; ed_b = 0;
    for (int c = 0; c < 400; c++) begin
      if (!pa) begin
        pa = ($urandom_range(0, 1) == 1);
        WE_A = $urandom_range(0, 1);
        ADDR_A = 14'($urandom_range(0, 15));
        DI_A = $urandom_range(0, 1);
      end
      if (!pb) begin
        pb = ($urandom_range(0, 1) == 1);
        WE_B = $urandom_range(0, 1);
        ADDR_B = 14'($urandom_range(0, 15));
        DI_B = $urandom_range(0, 1);
      end
      REQ_A = pa; REQ_B = pb;
      if (pa && pb) begin
        ga = last_was_b;
        gb = !last_was_b;
      end else begin
        ga = pa;
        gb = pb;
      end
      wa = ga ? ADDR_A : ADDR_B;
      @(negedge CLK);
      checks++;
      if (ACK_A !== ga || ACK_B !== gb ||
          ((ga || gb) && RAM_ADDR !== wa)) begin
        fails++;
        $display("FAIL rnd_ack[%0d] a=%b b=%b addr=%h want %b %b %h",
                 c, ACK_A, ACK_B, RAM_ADDR, ga, gb, wa);
      end
      checks++;
      if (RVALID_A !== ev_a || RVALID_B !== ev_b ||
          (ev_a && RDATA_A !== ed_a) || (ev_b && RDATA_B !== ed_b)) begin
        fails++;
        $display("FAIL rnd_rd[%0d] rva=%b rvb=%b do=%b want %b %b a=%b b=%b",
                 c, RVALID_A, RVALID_B, RAM_DO, ev_a, ev_b, ed_a, ed_b);
      end
      ev_a = ga && !WE_A;
      ev_b = gb && !WE_B;
      if (ev_a) ed_a = ref_mem[ADDR_A];
      if (ev_b) ed_b = ref_mem[ADDR_B];
      if (ga && WE_A) ref_mem[ADDR_A] = DI_A;
      if (gb && WE_B) ref_mem[ADDR_B] = DI_B;
      if (ga) begin
        pa = 0;
        last_was_b = 0;
      end
      if (gb) begin
        pb = 0;
        last_was_b = 1;
      end
      tick();
    end
    idle_in();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_clear();
    test_clear_reset();
    test_clear_restart();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
